// File: rtl/spm_ctrl_pkg.sv
// Shared types and constants for the serial-parallel multiplier controller.
package spm_ctrl_pkg;

  localparam int SPM_CTRL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } spm_state_e;

  // One y bit per cycle for 2*WIDTH bits, plus the multiplier pipeline latency
  function automatic int run_cycles(input int width, input int lat);
    return 2 * width + lat;
  endfunction

endpackage

// File: rtl/spm_ctrl_if.sv
// Request/response handshake plus the serial-parallel multiplier hookup for spm_ctrl.
interface spm_ctrl_if
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH = SPM_CTRL_WIDTH
);

  logic               req_valid_i;
  logic               req_ready_o;
  logic [WIDTH-1:0]   mc_i;
  logic [WIDTH-1:0]   mp_i;
  logic               abort_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [2*WIDTH-1:0] prod_o;
  logic               busy_o;
  logic [WIDTH-1:0]   spm_x_o;
  logic               spm_y_o;
  logic               spm_clr_o;
  logic               spm_p_i;

  // The controller is the slave of the request/response handshake
  modport slave (
    input  req_valid_i, mc_i, mp_i, abort_i, rsp_ready_i, spm_p_i,
    output req_ready_o, rsp_valid_o, prod_o, busy_o, spm_x_o, spm_y_o, spm_clr_o
  );

  modport master (
    output req_valid_i, mc_i, mp_i, abort_i, rsp_ready_i, spm_p_i,
    input  req_ready_o, rsp_valid_o, prod_o, busy_o, spm_x_o, spm_y_o, spm_clr_o
  );

endinterface

// File: rtl/spm_ctrl.sv
// Sequencer for an external serial-parallel multiplier: latches operands, streams y LSB first,
// reassembles the serial product. Define SPM_CTRL_SIGNED_EN for two's-complement operation.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH   = SPM_CTRL_WIDTH,
  parameter int SPM_LAT = 1
) (
  input logic       clk_i,
  input logic       rst_ni,
  spm_ctrl_if.slave bus
);

  localparam int RUN_CYCLES = run_cycles(WIDTH, SPM_LAT);
  localparam int CNT_W      = $clog2(RUN_CYCLES + 1);
  localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAT   = CNT_W'(SPM_LAT);

  spm_state_e         state_q;
  spm_state_e         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mc_q;
  logic [WIDTH-1:0]   mp_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               accept;
  logic               run_last;
  logic               ext_bit;
  logic               y_bit;
  logic [IDX_W-1:0]   y_idx;

  assign accept   = bus.req_valid_i && (state_q == IDLE);
  assign run_last = (cnt_q == CNT_LAST);
  assign y_idx    = cnt_q[IDX_W-1:0];

  // Bits of y past WIDTH extend the operand to 2*WIDTH bits
`ifdef SPM_CTRL_SIGNED_EN
  assign ext_bit = mp_q[WIDTH-1];
`else
  assign ext_bit = 1'b0;
`endif

  assign y_bit = (cnt_q < CNT_WIDTH) ? mp_q[y_idx] : ext_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = bus.abort_i ? IDLE : RUN;
      end
      RUN: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (run_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_ready_o = 1'b0;
    bus.busy_o      = 1'b0;
    bus.spm_clr_o   = 1'b0;
    bus.spm_y_o     = 1'b0;
    bus.rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
      end
      CLEAR: begin
        bus.busy_o    = 1'b1;
        bus.spm_clr_o = 1'b1;
      end
      RUN: begin
        bus.busy_o  = 1'b1;
        bus.spm_y_o = y_bit;
      end
      DONE: begin
        bus.rsp_valid_o = 1'b1;
      end
      default: begin
        bus.req_ready_o = 1'b0;
      end
    endcase
  end

  // Counter sits at zero outside RUN, so every operation starts its count fresh
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if ((state_q == RUN) && (state_d == RUN)) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mc_q <= '0;
      mp_q <= '0;
    end else if (accept) begin
      mc_q <= bus.mc_i;
      mp_q <= bus.mp_i;
    end
  end

  // Product bits arrive LSB first once the multiplier pipeline has filled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
    end else if ((state_q == RUN) && (cnt_q >= CNT_LAT)) begin
      prod_q <= {bus.spm_p_i, prod_q[2*WIDTH-1:1]};
    end
  end

  assign bus.prod_o  = prod_q;
  assign bus.spm_x_o = mc_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl with a behavioural serial-parallel multiplier and a timeline scoreboard.
module tb_spm_ctrl;

  localparam int W       = 32;
  localparam int LAT     = 1;
  localparam int T_VALID = 2 * W + LAT + 2;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  bit   cmp_en;

  spm_ctrl_if #(.WIDTH(W)) bus ();

  spm_ctrl #(.WIDTH(W), .SPM_LAT(LAT)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ext_x(input logic [31:0] a);
`ifdef SPM_CTRL_SIGNED_EN
    return {{32{a[31]}}, a};
`else
    return {32'b0, a};
`endif
  endfunction

  function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef SPM_CTRL_SIGNED_EN
    return $signed(ext_x(a)) * $signed({{32{b[31]}}, b});
`else
    return ext_x(a) * {32'b0, b};
`endif
  endfunction

  function automatic logic exp_y(input logic [31:0] b, input int k);
    if (k < W) return b[k];
`ifdef SPM_CTRL_SIGNED_EN
    return b[31];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] spm_sum(input logic [63:0] acc, input logic y,
                                          input logic [31:0] x, input int t);
    return y ? (acc + (ext_x(x) << t)) : acc;
  endfunction

  // Multiplier model: y bit t is worth x*2^t; bit t of the running sum is final once added
  logic [63:0] spm_acc;
  int          spm_t;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spm_acc     <= '0;
      spm_t       <= 0;
      bus.spm_p_i <= 1'b0;
    end else if (bus.spm_clr_o) begin
      spm_acc     <= '0;
      spm_t       <= 0;
      bus.spm_p_i <= 1'b0;
    end else if (spm_t < 2 * W) begin
      spm_acc     <= spm_sum(spm_acc, bus.spm_y_o, bus.spm_x_o, spm_t);
      bus.spm_p_i <= spm_sum(spm_acc, bus.spm_y_o, bus.spm_x_o, spm_t) >> spm_t;
      spm_t       <= spm_t + 1;
    end
  end

  // Scoreboard timeline: m_cyc counts cycles since the acceptance edge
  bit          m_busy;
  bit          m_valid;
  int          m_cyc;
  logic [31:0] m_mc;
  logic [31:0] m_mp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cyc   <= 0;
      m_mc    <= '0;
      m_mp    <= '0;
    end else if (m_valid) begin
      if (bus.rsp_ready_i) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_cyc <= m_cyc + 1;
      if (bus.abort_i) begin
        m_busy <= 1'b0;
      end else if (m_cyc == T_VALID - 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
    end else if (bus.req_valid_i) begin
      m_busy <= 1'b1;
      m_cyc  <= 1;
      m_mc   <= bus.mc_i;
      m_mp   <= bus.mp_i;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check_output("req_ready", 64'(bus.req_ready_o), 64'(!m_busy && !m_valid));
      check_output("busy", 64'(bus.busy_o), 64'(m_busy));
      check_output("spm_clr", 64'(bus.spm_clr_o), 64'(m_busy && m_cyc == 1));
      check_output("spm_y", 64'(bus.spm_y_o), 64'((m_busy && m_cyc >= 2) ? exp_y(m_mp, m_cyc - 2) : 1'b0));
      check_output("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_valid));
      check_output("spm_x", 64'(bus.spm_x_o), 64'(m_mc));
      if (m_valid) check_output("prod", bus.prod_o, exp_prod(m_mc, m_mp));
    end
  end

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input int hold,
                                input bit abort_in_done, input logic [63:0] lit, input string name);
    int n;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b1;
    bus.mc_i        = a;
    bus.mp_i        = b;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid_o && n < 200);
    check_output({name, " latency"}, 64'(n), 64'(T_VALID));
    check_output({name, " product"}, bus.prod_o, lit);
    for (int i = 0; i < hold; i++) begin
      bus.abort_i = abort_in_done;
      @(negedge clk);
      check_output({name, " held product"}, bus.prod_o, lit);
      check_output({name, " held ready"}, 64'(bus.req_ready_o), 64'd0);
    end
    bus.abort_i     = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    check_output({name, " idle after take"}, 64'(bus.req_ready_o), 64'd1);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b1;
    bus.mc_i        = a;
    bus.mp_i        = b;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic expect_silence(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen++;
    end
    check_output({name, " no response"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    cmp_en          = 1'b0;
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.mc_i        = '0;
    bus.mp_i        = '0;
    bus.abort_i     = 1'b0;
    bus.rsp_ready_i = 1'b0;

    #3;
    check_output("reset prod", bus.prod_o, 64'd0);
    check_output("reset req_ready", 64'(bus.req_ready_o), 64'd1);
    check_output("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_output("reset busy", 64'(bus.busy_o), 64'd0);
    check_output("reset spm_clr", 64'(bus.spm_clr_o), 64'd0);
    check_output("reset spm_y", 64'(bus.spm_y_o), 64'd0);
    check_output("reset spm_x", 64'(bus.spm_x_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_en = 1'b1;

    apply_stimulus(32'd3, 32'd5, 0, 1'b0, 64'd15, "3x5");
`ifdef SPM_CTRL_SIGNED_EN
    apply_stimulus(32'hFFFF_FFFD, 32'd5, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, "neg3x5");
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b1, 64'd1, "max backpressure");
    apply_stimulus(32'h8000_0000, 32'd3, 0, 1'b0, 64'hFFFF_FFFE_8000_0000, "minx3");
`else
    apply_stimulus(32'hFFFF_FFFD, 32'd5, 0, 1'b0, 64'h0000_0004_FFFF_FFF1, "neg3x5");
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b1, 64'hFFFF_FFFE_0000_0001, "max backpressure");
    apply_stimulus(32'h8000_0000, 32'd3, 0, 1'b0, 64'h0000_0001_8000_0000, "minx3");
`endif
    apply_stimulus(32'h8000_0000, 32'h8000_0000, 0, 1'b0, 64'h4000_0000_0000_0000, "min squared");

    // Abort at RUN counter 20: acceptance edge, CLEAR edge, then 20 RUN edges
    start_op(32'h0000_0011, 32'h0F0F_0F0F);
    repeat (21) @(posedge clk);
    #1;
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus.abort_i = 1'b0;
    @(negedge clk);
    check_output("abort busy", 64'(bus.busy_o), 64'd0);
    check_output("abort ready", 64'(bus.req_ready_o), 64'd1);
    expect_silence("abort", 80);

    // Reset pulse in the middle of a second operation
    start_op(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_output("midreset prod", bus.prod_o, 64'd0);
    check_output("midreset busy", 64'(bus.busy_o), 64'd0);
    check_output("midreset ready", 64'(bus.req_ready_o), 64'd1);
    check_output("midreset spm_x", 64'(bus.spm_x_o), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    expect_silence("midreset", 80);

    apply_stimulus(32'd7, 32'd9, 0, 1'b0, 64'd63, "7x9 after reset");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spm_ctrl.md
SPM_CTRL -- requirements
Module: spm_ctrl

Interface
REQ-001: Parameter WIDTH, default 32, SHALL be the operand width in bits.
REQ-002: Parameter SPM_LAT, default 1, SHALL be the number of cycles from a y bit entering the multiplier to its product bit appearing on spm_p_i.
REQ-003: clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005: req_valid_i  input  1  SHALL signal that an operand pair is offered.
REQ-006: req_ready_o  output  1  SHALL signal that the controller accepts an operand pair this cycle.
REQ-007: mc_i  input  WIDTH  SHALL be the multiplicand (parallel x operand).
REQ-008: mp_i  input  WIDTH  SHALL be the multiplier (serialised y operand).
REQ-009: abort_i  input  1  SHALL request cancellation of an in-flight operation.
REQ-010: rsp_valid_o  output  1  SHALL signal that prod_o holds a valid product.
REQ-011: rsp_ready_i  input  1  SHALL signal that the consumer takes the product.
REQ-012: prod_o  output  2*WIDTH  SHALL carry the product.
REQ-013: busy_o  output  1  SHALL be high in CLEAR and RUN.
REQ-014: spm_x_o  output  WIDTH  SHALL drive the multiplier's parallel operand.
REQ-015: spm_y_o  output  1  SHALL drive the multiplier's serial operand bit.
REQ-016: spm_clr_o  output  1  SHALL clear the multiplier's internal accumulator.
REQ-017: spm_p_i  input  1  SHALL be the multiplier's serial product bit.

Function
REQ-018: FSM states SHALL be IDLE, CLEAR, RUN and DONE.
REQ-019: req_ready_o SHALL equal (state==IDLE); a request is accepted on a cycle where req_valid_i && req_ready_o, then IDLE->CLEAR.
REQ-020: On acceptance, mc_i and mp_i SHALL be latched; spm_x_o SHALL hold the latched mc until the next acceptance.
REQ-021: CLEAR SHALL last one cycle with spm_clr_o=1, then move to RUN; spm_clr_o SHALL be 0 in all other states.
REQ-022: RUN SHALL last exactly 2*WIDTH+SPM_LAT cycles, counted by an internal counter that starts at 0.
REQ-023: In RUN, for counter k<WIDTH, spm_y_o SHALL be mp[k] (LSB first); for k>=WIDTH it SHALL be the extension bit (REQ-033/034).
REQ-024: In RUN, for counter k>=SPM_LAT, spm_p_i SHALL be shifted into the MSB of the product register (right shift), giving exactly 2*WIDTH captures.
REQ-025: After the last RUN cycle the FSM SHALL enter DONE with rsp_valid_o=1; rsp_valid_o SHALL first be high 2*WIDTH+SPM_LAT+2 cycles after the acceptance edge (67 for the defaults).
REQ-026: In DONE, prod_o and rsp_valid_o SHALL hold stable until rsp_ready_i=1, then the FSM SHALL return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027: abort_i in CLEAR or RUN SHALL force IDLE on the next edge with no response; abort_i SHALL be ignored in IDLE and DONE.
REQ-028: prod_o SHALL be the product register, which changes only in RUN.
REQ-029: spm_y_o SHALL be 0 outside RUN.

Reset
REQ-030: While rst_ni=0: state=IDLE, counter=0, product register=0, latched operands=0, rsp_valid_o=0, busy_o=0, spm_clr_o=0, spm_y_o=0, and req_ready_o=1.
REQ-031: A reset asserted mid-RUN SHALL discard the operation; the next accepted request SHALL complete normally, because CLEAR always precedes RUN.

Configuration
REQ-032: Macro SPM_CTRL_SIGNED_EN SHALL select signed operation.
REQ-033: With SPM_CTRL_SIGNED_EN defined: the extension bit SHALL be mp[WIDTH-1], and prod_o SHALL be the two's-complement signed product, given an SPM configured for signed x.
REQ-034: Without SPM_CTRL_SIGNED_EN: the extension bit SHALL be 0, and prod_o SHALL be the unsigned product.

Structure
REQ-035: Package spm_ctrl_pkg SHALL hold the FSM state enum and the default width constant SPM_CTRL_WIDTH=32.
REQ-036: No sub-module SHALL be used; the SPM datapath is instantiated outside this block.

Verification
REQ-037: Bench SHALL connect a behavioural SPM model with SPM_LAT=1 and WIDTH=32 for all scenarios.
REQ-038: Unsigned: mc=3, mp=5 -> prod_o=15, rsp_valid_o rising 67 cycles after acceptance.
REQ-039: mc=0xFFFFFFFD, mp=5 -> prod_o=0xFFFFFFFFFFFFFFF1 with the macro, and 0x00000004FFFFFFF1 without it.
REQ-040: Maximum unsigned: mc=mp=0xFFFFFFFF -> prod_o=0xFFFFFFFE00000001.
REQ-041: Backpressure: rsp_ready_i held low 10 cycles in DONE -> prod_o stable, req_ready_o=0 throughout; IDLE one cycle after rsp_ready_i=1.
REQ-042: abort_i at RUN counter 20, then rst_ni pulsed low mid-RUN of a second op -> no rsp_valid_o for either; a third op (mc=7, mp=9) returns 63.
